// File: rtl/serial_digit_adder.sv
// Purpose : multi-cycle adder/subtractor, DIGIT bits per clock with a registered inter-slice carry.
// Latency : start accepted at edge k -> result and done pulse after edge k+NSLICE (NSLICE = WIDTH/DIGIT).
// Backpressure: none; start is ignored while busy, and a start held in DONE chains the next operation.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, sub, a, b,   operation request; operands captured on the accepting edge
//   cin                 carry-in for add mode (ignored when sub = 1)
//   busy, done          busy while computing; done pulses for one cycle when the result updates
//   sum, cout, overflow result, carry out of the MSB (1 = no borrow for subtract), signed overflow
//
// Parameters: WIDTH >= 2, DIGIT >= 1, and DIGIT must divide WIDTH exactly.
module serial_digit_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int NSLICE = WIDTH / DIGIT;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] part_q, part_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Slice datapath
   logic [DIGIT:0]   slice;
   logic             msb_cin;
   logic [WIDTH-1:0] part_next;
   logic [WIDTH-1:0] op_a_shift;
   logic [WIDTH-1:0] op_b_shift;

   assign slice = {1'b0, op_a_q[DIGIT-1:0]} + {1'b0, op_b_q[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, carry_q};

   // Carry into the top bit of the slice: recover it from that bit's sum and inputs.
   // On the last slice this is the carry into the operand MSB.
   assign msb_cin = slice[DIGIT-1] ^ op_a_q[DIGIT-1] ^ op_b_q[DIGIT-1];

   // Result bits enter at the top of the partial register and move down, so after
   // NSLICE slices the first (least significant) slice sits at bit 0.
   generate
      if (DIGIT == WIDTH) begin : g_single
         assign part_next  = slice[DIGIT-1:0];
         assign op_a_shift = '0;
         assign op_b_shift = '0;
      end else begin : g_multi
         assign part_next  = {slice[DIGIT-1:0], part_q[WIDTH-1:DIGIT]};
         assign op_a_shift = {{DIGIT{1'b0}}, op_a_q[WIDTH-1:DIGIT]};
         assign op_b_shift = {{DIGIT{1'b0}}, op_b_q[WIDTH-1:DIGIT]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      part_d  = part_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               // Subtract is a + ~b + 1: invert B once here and seed the carry with 1.
               op_a_d  = a;
               op_b_d  = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            op_a_d  = op_a_shift;
            op_b_d  = op_b_shift;
            carry_d = slice[DIGIT];
            part_d  = part_next;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_CNT) begin
               sum_d   = part_next;
               cout_d  = slice[DIGIT];
               ovf_d   = msb_cin ^ slice[DIGIT];
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Status outputs are registered copies of the next state.
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         part_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         part_q  <= part_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Bench for serial_digit_adder: directed cases on WIDTH=8/DIGIT=2 plus a random
// sweep over DIGIT 1/2/4/8 at WIDTH=8 and WIDTH=16/DIGIT=4, against an
// arithmetic reference model.
module tb_serial_digit_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [4:0]  start_v;
   logic        sub_in;
   logic        cin_in;
   logic [15:0] a_in;
   logic [15:0] b_in;

   logic        busy_o [5];
   logic        done_o [5];
   logic        cout_o [5];
   logic        ovf_o  [5];
   logic [7:0]  sum_d1, sum_d2, sum_d4, sum_d8;
   logic [15:0] sum_w16;

   int errors = 0;
   int checks = 0;

   // Instance 1 (WIDTH=8, DIGIT=2) is the one the directed tests use.
   int cfg_w  [5] = '{8, 8, 8, 8, 16};
   int cfg_ns [5] = '{8, 4, 2, 1, 4};

   serial_digit_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .reset_n(reset_n), .start(start_v[0]), .sub(sub_in),
      .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
      .busy(busy_o[0]), .done(done_o[0]), .sum(sum_d1), .cout(cout_o[0]), .overflow(ovf_o[0]));
   serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
      .clk(clk), .reset_n(reset_n), .start(start_v[1]), .sub(sub_in),
      .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
      .busy(busy_o[1]), .done(done_o[1]), .sum(sum_d2), .cout(cout_o[1]), .overflow(ovf_o[1]));
   serial_digit_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .reset_n(reset_n), .start(start_v[2]), .sub(sub_in),
      .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
      .busy(busy_o[2]), .done(done_o[2]), .sum(sum_d4), .cout(cout_o[2]), .overflow(ovf_o[2]));
   serial_digit_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .reset_n(reset_n), .start(start_v[3]), .sub(sub_in),
      .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
      .busy(busy_o[3]), .done(done_o[3]), .sum(sum_d8), .cout(cout_o[3]), .overflow(ovf_o[3]));
   serial_digit_adder #(.WIDTH(16), .DIGIT(4)) u_w16 (
      .clk(clk), .reset_n(reset_n), .start(start_v[4]), .sub(sub_in),
      .a(a_in), .b(b_in), .cin(cin_in),
      .busy(busy_o[4]), .done(done_o[4]), .sum(sum_w16), .cout(cout_o[4]), .overflow(ovf_o[4]));

   // Observation mux for the instance currently under test.
   int          sel = 1;
   logic        sel_busy, sel_done, sel_cout, sel_ovf;
   logic [15:0] sel_sum;

   always_comb begin
      sel_busy = busy_o[sel];
      sel_done = done_o[sel];
      sel_cout = cout_o[sel];
      sel_ovf  = ovf_o[sel];
      case (sel)
         0:       sel_sum = {8'h00, sum_d1};
         1:       sel_sum = {8'h00, sum_d2};
         2:       sel_sum = {8'h00, sum_d4};
         3:       sel_sum = {8'h00, sum_d8};
         default: sel_sum = sum_w16;
      endcase
   end

   // Reference: plain two's-complement arithmetic on w-bit values.
   function automatic void ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                     input logic sub, input logic cin,
                                     output logic [15:0] s, output logic c, output logic v);
      logic [16:0] full;
      logic [15:0] mask;
      logic [15:0] am, bm;
      logic        sa, sb, ss;
      mask = 16'((32'd1 << w) - 32'd1);
      am   = a & mask;
      bm   = b & mask;
      if (sub) full = {1'b0, am} + {1'b0, (~bm) & mask} + 17'd1;
      else     full = {1'b0, am} + {1'b0, bm} + {16'd0, cin};
      s  = full[15:0] & mask;
      c  = full[w];
      sa = am[w-1];
      sb = bm[w-1];
      ss = s[w-1];
      // add overflows when both signs agree and the result sign differs;
      // subtract overflows when the signs differ and the result takes B's sign
      v  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
   endfunction

   // Drive one operation on instance idx and wait for its done pulse.
   // lat counts edges from the accepting edge to the edge that raises done, inclusive.
   task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin,
                         output logic [15:0] s, output logic c, output logic v,
                         output int lat, output int bcnt, output bit tmo);
      sel          = idx;
      a_in         = a;
      b_in         = b;
      sub_in       = sub;
      cin_in       = cin;
      start_v[idx] = 1'b1;
      @(posedge clk); #1;
      start_v[idx] = 1'b0;
      lat  = 1;
      bcnt = 0;
      tmo  = 1'b0;
      while (sel_done !== 1'b1) begin
         if (sel_busy === 1'b1) bcnt++;
         if (lat > 40) begin
            tmo = 1'b1;
            break;
         end
         @(posedge clk); #1;
         lat++;
      end
      s = sel_sum;
      c = sel_cout;
      v = sel_ovf;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start_v = '0;
      sub_in  = 1'b0;
      cin_in  = 1'b0;
      a_in    = '0;
      b_in    = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (busy_o[1] !== 1'b0 || done_o[1] !== 1'b0)
         $display("FAIL reset_status: busy=%b done=%b, required 0 0", busy_o[1], done_o[1]);
      checks++;
      if (sum_d2 !== 8'h00 || cout_o[1] !== 1'b0 || ovf_o[1] !== 1'b0)
         $display("FAIL reset_result: sum=%h cout=%b ovf=%b, required 00 0 0", sum_d2, cout_o[1], ovf_o[1]);
      if (sum_d2 !== 8'h00 || cout_o[1] !== 1'b0 || ovf_o[1] !== 1'b0 || busy_o[1] !== 1'b0 || done_o[1] !== 1'b0)
         errors++;
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add_overflow();
      logic [15:0] s; logic c, v; int lat, bcnt; bit tmo;
      run_op(1, 16'h5A, 16'h3C, 1'b0, 1'b0, s, c, v, lat, bcnt, tmo);
      checks++;
      if (tmo || s !== 16'h96 || c !== 1'b0 || v !== 1'b1) begin
         errors++;
         $display("FAIL add_ovf: sum=%h cout=%b ovf=%b tmo=%0d, required 96 0 1", s, c, v, tmo);
      end
      checks++;
      if (bcnt != 4 || lat != 5) begin
         errors++;
         $display("FAIL add_ovf_timing: busy_cycles=%0d latency=%0d, required 4 5", bcnt, lat);
      end
      checks++;
      if (sel_busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_in_done: busy=%b, required 0", sel_busy);
      end
      @(posedge clk); #1;
      checks++;
      if (sel_done !== 1'b0 || sel_busy !== 1'b0 || sel_sum !== 16'h96) begin
         errors++;
         $display("FAIL done_one_cycle: done=%b busy=%b sum=%h, required 0 0 96", sel_done, sel_busy, sel_sum);
      end
   endtask

   task automatic test_wrap_carry();
      logic [15:0] s; logic c, v; int lat, bcnt; bit tmo;
      run_op(1, 16'hFF, 16'h01, 1'b0, 1'b0, s, c, v, lat, bcnt, tmo);
      checks++;
      if (tmo || s !== 16'h00 || c !== 1'b1 || v !== 1'b0) begin
         errors++;
         $display("FAIL add_wrap: sum=%h cout=%b ovf=%b, required 00 1 0", s, c, v);
      end
      run_op(1, 16'h7F, 16'h00, 1'b0, 1'b1, s, c, v, lat, bcnt, tmo);
      checks++;
      if (tmo || s !== 16'h80 || c !== 1'b0 || v !== 1'b1) begin
         errors++;
         $display("FAIL add_cin: sum=%h cout=%b ovf=%b, required 80 0 1", s, c, v);
      end
   endtask

   task automatic test_subtract();
      logic [15:0] s; logic c, v; int lat, bcnt; bit tmo;
      run_op(1, 16'h10, 16'h20, 1'b1, 1'b1, s, c, v, lat, bcnt, tmo);
      checks++;
      if (tmo || s !== 16'hF0 || c !== 1'b0 || v !== 1'b0) begin
         errors++;
         $display("FAIL sub_borrow: sum=%h cout=%b ovf=%b, required f0 0 0", s, c, v);
      end
      run_op(1, 16'h80, 16'h01, 1'b1, 1'b1, s, c, v, lat, bcnt, tmo);
      checks++;
      if (tmo || s !== 16'h7F || c !== 1'b1 || v !== 1'b1) begin
         errors++;
         $display("FAIL sub_ovf: sum=%h cout=%b ovf=%b, required 7f 1 1", s, c, v);
      end
   endtask

   task automatic test_ignore_mid_run();
      int lat;
      sel        = 1;
      a_in       = 16'h12;
      b_in       = 16'h34;
      sub_in     = 1'b0;
      cin_in     = 1'b0;
      start_v[1] = 1'b1;
      @(posedge clk); #1;
      start_v[1] = 1'b0;
      lat = 1;
      while (sel_done !== 1'b1 && lat <= 40) begin
         if (lat == 2) begin
            a_in       = 16'hAA;
            b_in       = 16'h55;
            sub_in     = 1'b1;
            start_v[1] = 1'b1;
         end else begin
            start_v[1] = 1'b0;
         end
         if (lat == 3) begin
            // previous result (0x80 - 0x01) must still be on the outputs
            checks++;
            if (sel_sum !== 16'h7F || sel_busy !== 1'b1) begin
               errors++;
               $display("FAIL hold_during_run: sum=%h busy=%b, required 7f 1", sel_sum, sel_busy);
            end
         end
         @(posedge clk); #1;
         lat++;
      end
      start_v[1] = 1'b0;
      checks++;
      if (lat != 5 || sel_sum !== 16'h46 || sel_cout !== 1'b0 || sel_ovf !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start: sum=%h cout=%b ovf=%b latency=%0d, required 46 0 0 5",
                  sel_sum, sel_cout, sel_ovf, lat);
      end
      @(posedge clk); #1;
      checks++;
      if (sel_busy !== 1'b0 || sel_done !== 1'b0) begin
         errors++;
         $display("FAIL ignore_no_queue: busy=%b done=%b, required 0 0", sel_busy, sel_done);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] qa [5];
      logic [15:0] qb [5];
      logic        qs [5];
      logic        qc [5];
      logic [15:0] es, prev;
      logic        ec, ev;
      bit          have_prev;
      int          lat;
      for (int i = 0; i < 5; i++) begin
         qa[i] = 16'($urandom_range(0, 255));
         qb[i] = 16'($urandom_range(0, 255));
         qs[i] = 1'($urandom_range(0, 1));
         qc[i] = 1'($urandom_range(0, 1));
      end
      sel        = 1;
      have_prev  = 1'b0;
      prev       = '0;
      a_in       = qa[0];
      b_in       = qb[0];
      sub_in     = qs[0];
      cin_in     = qc[0];
      start_v[1] = 1'b1;
      @(posedge clk); #1;
      for (int r = 0; r < 4; r++) begin
         // operands for the next acceptance; the running operation must not see them
         a_in   = qa[r+1];
         b_in   = qb[r+1];
         sub_in = qs[r+1];
         cin_in = qc[r+1];
         if (r == 3) start_v[1] = 1'b0;
         lat = 1;
         while (sel_done !== 1'b1 && lat <= 40) begin
            if (have_prev) begin
               checks++;
               if (sel_sum !== prev) begin
                  errors++;
                  $display("FAIL b2b_stable: op=%0d sum=%h, required %h", r, sel_sum, prev);
               end
            end
            @(posedge clk); #1;
            lat++;
         end
         ref_model(8, qa[r], qb[r], qs[r], qc[r], es, ec, ev);
         checks++;
         if (lat != 5 || sel_sum !== es || sel_cout !== ec || sel_ovf !== ev) begin
            errors++;
            $display("FAIL b2b_result: op=%0d sum=%h cout=%b ovf=%b latency=%0d, required %h %b %b 5",
                     r, sel_sum, sel_cout, sel_ovf, lat, es, ec, ev);
         end
         prev      = es;
         have_prev = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (sel_busy !== (r < 3)) begin
            errors++;
            $display("FAIL b2b_restart: op=%0d busy=%b, required %b", r, sel_busy, (r < 3));
         end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [15:0] s; logic c, v; int lat, bcnt; bit tmo;
      bit saw_done;
      run_op(1, 16'h01, 16'h01, 1'b0, 1'b0, s, c, v, lat, bcnt, tmo);
      checks++;
      if (tmo || s !== 16'h02) begin
         errors++;
         $display("FAIL rst_pre_op: sum=%h, required 02", s);
      end
      @(posedge clk); #1;
      sel        = 1;
      a_in       = 16'h33;
      b_in       = 16'h11;
      sub_in     = 1'b0;
      cin_in     = 1'b0;
      start_v[1] = 1'b1;
      @(posedge clk); #1;
      start_v[1] = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (sel_sum !== 16'h00 || sel_busy !== 1'b0 || sel_done !== 1'b0 || sel_cout !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_async: sum=%h busy=%b done=%b cout=%b, required 00 0 0 0",
                  sel_sum, sel_busy, sel_done, sel_cout);
      end
      saw_done = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (sel_done !== 1'b0 || sel_busy !== 1'b0) saw_done = 1'b1;
      end
      reset_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (sel_done !== 1'b0 || sel_busy !== 1'b0) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL rst_mid_quiet: done/busy seen after abort, required none");
      end
      run_op(1, 16'h33, 16'h11, 1'b0, 1'b0, s, c, v, lat, bcnt, tmo);
      checks++;
      if (tmo || s !== 16'h44 || c !== 1'b0 || v !== 1'b0 || lat != 5) begin
         errors++;
         $display("FAIL rst_post_op: sum=%h cout=%b ovf=%b latency=%0d, required 44 0 0 5", s, c, v, lat);
      end
   endtask

   task automatic test_sweep();
      logic [15:0] s, es, a, b, mask;
      logic        c, v, ec, ev, sb, ci;
      int          lat, bcnt;
      bit          tmo;
      for (int k = 0; k < 5; k++) begin
         mask = 16'((32'd1 << cfg_w[k]) - 32'd1);
         for (int n = 0; n < 1000; n++) begin
            a  = 16'($urandom) & mask;
            b  = 16'($urandom) & mask;
            sb = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            run_op(k, a, b, sb, ci, s, c, v, lat, bcnt, tmo);
            ref_model(cfg_w[k], a, b, sb, ci, es, ec, ev);
            checks++;
            if (tmo || (s & mask) !== es || c !== ec || v !== ev || lat != cfg_ns[k] + 1) begin
               errors++;
               $display("FAIL sweep W%0d/NS%0d: a=%h b=%h sub=%b cin=%b got %h %b %b lat=%0d, required %h %b %b lat=%0d",
                        cfg_w[k], cfg_ns[k], a, b, sb, ci, s & mask, c, v, lat, es, ec, ev, cfg_ns[k] + 1);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_wrap_carry();
      test_subtract();
      test_ignore_mid_run();
      test_back_to_back();
      test_reset_mid_op();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_digit_adder.md
# serial_digit_adder

Parametrised multi-cycle adder/subtractor. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, using a registered carry between digit slices. A start/busy/done handshake controls each operation. It replaces fixed-width chained full-adder blocks wherever operand width, area or timing makes a wide single-cycle ripple chain undesirable. It produces sum, carry-out and signed overflow.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2.
- DIGIT, 2: bits processed per cycle; must be ≥ 1 and divide WIDTH exactly.
- NSLICE (derived, not overridable): WIDTH/DIGIT, the number of compute cycles.
- clk  input  1  rising-edge clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled on the rising edge.
- sub  input  1  0 = a + b + cin; 1 = a − b (a + ~b + 1); cin is ignored when sub = 1.
- a  input  WIDTH  operand A, captured when start is accepted.
- b  input  WIDTH  operand B, captured when start is accepted.
- cin  input  1  carry-in for add mode, captured when start is accepted.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse when the result registers update.
- sum  output  WIDTH  result, low WIDTH bits.
- cout  output  1  carry out of the MSB; for subtract, 1 means no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **Accepting start:** start is accepted in IDLE or DONE; start is ignored in RUN. On acceptance:
  - op_a ← a and op_b ← (sub ? ~b : b).
  - carry ← (sub ? 1 : cin), and slice count ← 0.
  - The FSM goes to RUN.
- **Each RUN cycle:**
  - Add the low DIGIT bits of op_a and op_b plus carry.
  - Shift the DIGIT result bits into the top of the partial-result register (LSB slice first, shifting right).
  - Shift op_a and op_b right by DIGIT, update carry with the slice carry-out, and increment the count.
- **Last slice** (count = NSLICE−1):
  - The carry into the MSB comes from bit DIGIT−1 of the slice adder.
  - sum ← completed partial result; cout ← slice carry-out; overflow ← carry-into-MSB XOR cout.
  - The FSM goes to DONE.
- **DONE:** lasts one cycle with done = 1. It goes to RUN if start = 1, otherwise to IDLE.
- **Output stability:** sum, cout and overflow change only on a final-slice edge or on reset. They hold the previous result throughout RUN and until the next completion.
- **Arithmetic:** modulo 2^WIDTH. The operand registers are WIDTH wide, the slice adder is DIGIT+1 wide, and there is no sign extension.

## Timing
- **Reset values:** reset_n low forces, immediately and asynchronously:
  - state = IDLE;
  - busy = 0, done = 0;
  - sum = 0, cout = 0, overflow = 0;
  - internal operand, carry and count registers = 0.
- **Reset mid-operation:** asserting reset during RUN aborts the operation. No done pulse is produced and no result is written.
- **Latency**, with start accepted at edge k:
  - busy = 1 after edge k, through edge k+NSLICE.
  - The result is written and done = 1 after edge k+NSLICE.
  - busy = 0 in the DONE cycle.
  - Start-to-done latency is NSLICE+1 edges.
- **Throughput:** start held high continuously gives one result every NSLICE+1 cycles (DONE → RUN directly, with no IDLE cycle).
- **Input capture:** a, b, sub and cin are sampled only at the accepting edge; later changes have no effect on the current operation.
- **Single-slice case:** DIGIT = WIDTH gives NSLICE = 1, so RUN lasts exactly one cycle.

## Test plan
All cases use WIDTH=8 and DIGIT=2 unless stated otherwise.
- **Add with signed overflow:** a=0x5A, b=0x3C, cin=0, sub=0, 1-cycle start.
  - busy high for 4 cycles, then done pulses for 1 cycle.
  - Result: sum=0x96, cout=0, overflow=1.
- **Add wrap-around and carry-in:**
  - 0xFF+0x01, cin=0 → sum=0x00, cout=1, overflow=0.
  - 0x7F+0x00, cin=1 → sum=0x80, cout=0, overflow=1.
- **Subtract:**
  - 0x10−0x20 → sum=0xF0, cout=0, overflow=0.
  - 0x80−0x01 → sum=0x7F, cout=1, overflow=1.
  - cin=1 is applied in both cases and has no effect.
- **Handshake:**
  - A start pulse mid-RUN with different operands is ignored; the first result completes unchanged.
  - start held high → done every 5 cycles, and sum stays stable between done pulses.
- **Reset mid-operation:**
  - Complete 0x01+0x01 (sum=0x02).
  - Start 0x33+0x11, then pull reset_n low after 2 RUN cycles.
  - Expect sum=0, busy=0, no done pulse, and state IDLE.
  - A following start of 0x33+0x11 completes with sum=0x44.
- **Parameter sweep:** DIGIT ∈ {1,2,4,8} at WIDTH=8, plus WIDTH=16/DIGIT=4.
  - Apply 1000 random operands per configuration.
  - Check each result against a+b+cin and a−b, with latency = NSLICE+1.
